edge_filter_detector: RTL and testbench

- Parametrised, multi-channel successor to the single-bit CAN timing edge detector.
- Per channel, it synchronises each asynchronous input and applies a glitch filter. The filter only accepts a level after it has been stable for FILTER_LEN cycles.
- It emits registered single-cycle rising, falling and any-edge pulses, with an optional post-edge lockout window.
- Sits between the CAN RX pins and the bit-timing/resync logic; it also serves other slow asynchronous inputs.

---
 rtl/edge_filter_detector.sv | 119 +++++++++++
 tb/tb_edge_filter_detector.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/edge_filter_detector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// edge_filter_detector
// Multi-channel synchroniser, glitch filter and edge-pulse generator with an
// optional per-channel post-edge lockout window.
// Revision: 1.0
// ============================================================================
module edge_filter_detector #(
    parameter int   CHANNELS    = 1,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 3,
    parameter int   LOCKOUT     = 0,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [CHANNELS-1:0] signal_in,
    output logic [CHANNELS-1:0] signal_filtered,
    output logic [CHANNELS-1:0] edge_detected,
    output logic [CHANNELS-1:0] rising_edge,
    output logic [CHANNELS-1:0] falling_edge,
    output logic                edge_any
);

    localparam int c_cnt_w  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int c_lock_w = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_LEN - 1);

    generate
        for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
            logic [SYNC_STAGES-1:0] r_sync;
            logic [c_cnt_w-1:0]     r_cnt;
            logic                   r_filt;
            logic                   r_det;
            logic                   r_rise;
            logic                   r_fall;
            logic                   w_sync_out;
            logic                   w_event;
            logic                   w_locked;
            logic                   w_emit;

            assign w_sync_out = r_sync[SYNC_STAGES-1];
            // A new level is accepted on the cycle its count reaches the end.
            assign w_event    = enable && (w_sync_out != r_filt) && (r_cnt == c_cnt_last);
            assign w_emit     = w_event && !w_locked;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync <= {SYNC_STAGES{RESET_LEVEL}};
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], signal_in[ch]};
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_filt <= RESET_LEVEL;
                    r_cnt  <= '0;
                end else if (!enable) begin
                    // Track the line directly so re-enabling starts from the current level.
                    r_filt <= w_sync_out;
                    r_cnt  <= '0;
                end else if (w_sync_out == r_filt) begin
                    r_cnt  <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_filt <= w_sync_out;
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                end
            end

            if (LOCKOUT > 0) begin : g_lock
                localparam logic [c_lock_w-1:0] c_lock_load = c_lock_w'(LOCKOUT);
                logic [c_lock_w-1:0] r_lock;

                assign w_locked = (r_lock != '0);

                // Suppressed events neither pulse nor reload the window.
                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n) begin
                        r_lock <= '0;
                    end else if (!enable) begin
                        r_lock <= '0;
                    end else if (w_emit) begin
                        r_lock <= c_lock_load;
                    end else if (r_lock != '0) begin
                        r_lock <= r_lock - 1'b1;
                    end
                end
            end else begin : g_no_lock
                assign w_locked = 1'b0;
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_det  <= 1'b0;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_det  <= w_emit;
                    r_rise <= w_emit && w_sync_out;
                    r_fall <= w_emit && !w_sync_out;
                end
            end

            assign signal_filtered[ch] = r_filt;
            assign edge_detected[ch]   = r_det;
            assign rising_edge[ch]     = r_rise;
            assign falling_edge[ch]    = r_fall;
        end
    endgenerate

    assign edge_any = |edge_detected;

endmodule
`default_nettype wire

// File: tb/tb_edge_filter_detector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_edge_filter_detector
// Scoreboard bench: a 4-channel filtered instance and a 1-channel lockout one.
// Revision: 1.0
// ============================================================================
module tb_edge_filter_detector;

    // Pulse latency in edges from the drive point (just after edge c) = 1 + S + F - 1.
    localparam int LAT_A = 5;   // S=2, F=3
    localparam int LAT_B = 3;   // S=2, F=1

    typedef struct {
        int         at;
        logic [3:0] det;
        logic [3:0] ris;
        logic [3:0] fal;
    } exp_t;

    logic       clock;
    logic       reset_n;
    logic       en_a, en_b;
    logic [3:0] sig_a, filt_a, a_det, a_ris, a_fal;
    logic       a_any;
    logic       sig_b, filt_b, b_det, b_ris, b_fal, b_any;

    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_n   = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    edge_filter_detector #(
        .CHANNELS(4), .SYNC_STAGES(2), .FILTER_LEN(3), .LOCKOUT(0), .RESET_LEVEL(1'b1)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .enable(en_a), .signal_in(sig_a),
        .signal_filtered(filt_a), .edge_detected(a_det), .rising_edge(a_ris),
        .falling_edge(a_fal), .edge_any(a_any)
    );

    edge_filter_detector #(
        .CHANNELS(1), .SYNC_STAGES(2), .FILTER_LEN(1), .LOCKOUT(5), .RESET_LEVEL(1'b1)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .enable(en_b), .signal_in(sig_b),
        .signal_filtered(filt_b), .edge_detected(b_det), .rising_edge(b_ris),
        .falling_edge(b_fal), .edge_any(b_any)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic push_a(input logic [3:0] r, input logic [3:0] f);
        qa.push_back('{edge_n + LAT_A, r | f, r, f});
    endtask

    task automatic push_b(input logic r, input logic f);
        qb.push_back('{edge_n + LAT_B, {3'b0, r | f}, {3'b0, r}, {3'b0, f}});
    endtask

    always @(negedge clock) begin
        while (qa.size() > 0 && qa[0].at < edge_n) begin
            n_checks++; n_errors++;
            $display("FAIL a_missing: no pulse seen, expected det=%b at edge %0d", qa[0].det, qa[0].at);
            qa.delete(0);
        end
        if (a_any || (|a_det) || (|a_ris) || (|a_fal)) begin
            n_checks++;
            if (qa.size() == 0) begin
                n_errors++;
                $display("FAIL a_unexpected: det=%b ris=%b fal=%b any=%b at edge %0d, expected none",
                         a_det, a_ris, a_fal, a_any, edge_n);
            end else begin
                ea = qa.pop_front();
                if ({edge_n, a_det, a_ris, a_fal, a_any} !== {ea.at, ea.det, ea.ris, ea.fal, |ea.det}) begin
                    n_errors++;
                    $display("FAIL a_pulse: got edge=%0d det=%b ris=%b fal=%b any=%b, expected edge=%0d det=%b ris=%b fal=%b any=%b",
                             edge_n, a_det, a_ris, a_fal, a_any, ea.at, ea.det, ea.ris, ea.fal, |ea.det);
                end
            end
        end
    end

    always @(negedge clock) begin
        while (qb.size() > 0 && qb[0].at < edge_n) begin
            n_checks++; n_errors++;
            $display("FAIL b_missing: no pulse seen, expected det=%b at edge %0d", qb[0].det[0], qb[0].at);
            qb.delete(0);
        end
        if (b_any || b_det || b_ris || b_fal) begin
            n_checks++;
            if (qb.size() == 0) begin
                n_errors++;
                $display("FAIL b_unexpected: det=%b ris=%b fal=%b any=%b at edge %0d, expected none",
                         b_det, b_ris, b_fal, b_any, edge_n);
            end else begin
                eb = qb.pop_front();
                if ({edge_n, b_det, b_ris, b_fal, b_any} !== {eb.at, eb.det[0], eb.ris[0], eb.fal[0], eb.det[0]}) begin
                    n_errors++;
                    $display("FAIL b_pulse: got edge=%0d det=%b ris=%b fal=%b any=%b, expected edge=%0d det=%b ris=%b fal=%b any=%b",
                             edge_n, b_det, b_ris, b_fal, b_any, eb.at, eb.det[0], eb.ris[0], eb.fal[0], eb.det[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        n_checks++; n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        reset_n = 1'b0; en_a = 1'b1; en_b = 1'b1;
        sig_a = 4'b1111; sig_b = 1'b1;
        cyc(3);
        chk("rst_filt_a", filt_a, 4'b1111);
        chk("rst_filt_b", {3'b0, filt_b}, 4'b0001);
        chk("rst_pulses_a", a_det | a_ris | a_fal, 4'b0000);
        chk("rst_pulses_b", {b_any, b_det, b_ris, b_fal}, 4'b0000);
        reset_n = 1'b1;
        cyc(2);
        chk("post_rst_filt_a", filt_a, 4'b1111);

        // Clean 1->0 step on ch0: exact latency of level and pulse.
        sig_a = 4'b1110; push_a(4'b0000, 4'b0001);
        cyc(4);
        chk("t1_not_early", filt_a, 4'b1111);
        cyc(1);
        chk("t1_level", filt_a, 4'b1110);
        cyc(4);
        sig_a = 4'b1111; push_a(4'b0001, 4'b0000);
        cyc(8);

        // Two-cycle glitch is rejected, three-cycle pulse is accepted both ways.
        sig_a = 4'b1110; cyc(2);
        sig_a = 4'b1111; cyc(8);
        chk("glitch2_level", filt_a, 4'b1111);
        sig_a = 4'b1110; push_a(4'b0000, 4'b0001); cyc(3);
        sig_a = 4'b1111; push_a(4'b0001, 4'b0000); cyc(8);
        chk("pulse3_level", filt_a, 4'b1111);

        // Simultaneous ch0/ch3 edges, then staggered ch1/ch2 edges.
        sig_a = 4'b0110; push_a(4'b0000, 4'b1001); cyc(8);
        chk("ch03_level", filt_a, 4'b0110);
        sig_a = 4'b1111; push_a(4'b1001, 4'b0000); cyc(8);
        sig_a = 4'b1101; push_a(4'b0000, 4'b0010); cyc(1);
        sig_a = 4'b1001; push_a(4'b0000, 4'b0100); cyc(8);
        chk("ch12_level", filt_a, 4'b1001);
        sig_a = 4'b1111; push_a(4'b0110, 4'b0000); cyc(8);

        // Disabled: level follows the line, no pulse now or on re-enable.
        en_a = 1'b0; sig_a = 4'b1110; cyc(6);
        chk("dis_level", filt_a, 4'b1110);
        en_a = 1'b1; cyc(8);
        chk("reen_level", filt_a, 4'b1110);
        sig_a = 4'b1111; push_a(4'b0001, 4'b0000); cyc(8);

        // Lockout=5 with toggles every 4 cycles: emit, suppress, emit.
        sig_b = 1'b0; push_b(1'b0, 1'b1); cyc(4);
        sig_b = 1'b1; cyc(3);
        chk("lock_track", {3'b0, filt_b}, 4'b0001);
        cyc(1);
        sig_b = 1'b0; push_b(1'b0, 1'b1);
        // Event on the cycle lock goes 1->0 is suppressed; the next is emitted.
        cyc(5);
        sig_b = 1'b1; cyc(1);
        sig_b = 1'b0; push_b(1'b0, 1'b1);
        sig_a = 4'b1101;
        cyc(2);
        chk("bnd_suppressed_level", {3'b0, filt_b}, 4'b0001);
        cyc(1);
        chk("bnd_emitted_level", {3'b0, filt_b}, 4'b0000);

        // Reset mid-count (A ch1) and mid-lockout (B) takes effect at once.
        cyc(1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_filt_a", filt_a, 4'b1111);
        chk("mid_rst_filt_b", {3'b0, filt_b}, 4'b0001);
        chk("mid_rst_pulses_a", a_det | a_ris | a_fal, 4'b0000);
        chk("mid_rst_any", {2'b0, a_any, b_any}, 4'b0000);
        sig_a = 4'b1111; sig_b = 1'b1;
        cyc(1);
        reset_n = 1'b1;
        sig_b = 1'b0; push_b(1'b0, 1'b1);
        cyc(10);
        chk("end_filt_a", filt_a, 4'b1111);
        chk("end_filt_b", {3'b0, filt_b}, 4'b0000);

        cyc(2);
        while (qa.size() > 0) begin
            n_checks++; n_errors++;
            $display("FAIL a_left: expected det=%b at edge %0d never seen", qa[0].det, qa[0].at);
            qa.delete(0);
        end
        while (qb.size() > 0) begin
            n_checks++; n_errors++;
            $display("FAIL b_left: expected det=%b at edge %0d never seen", qb[0].det[0], qb[0].at);
            qb.delete(0);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
